// File: rtl/rggen_rtl_pkg.sv
// Shared register-bus types: access direction and response status.
package rggen_rtl_pkg;

  typedef enum logic {
    RGGEN_READ  = 1'b0,
    RGGEN_WRITE = 1'b1
  } rggen_direction;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;

endpackage

// File: rtl/rggen_apb_bridge.sv
// Converts one register-bus request into one APB4 transfer.
// Fixed 3-cycle minimum latency. ACCESS stalls on pready, with an optional timeout.
module rggen_apb_bridge
  import rggen_rtl_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 0
)(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      bus_request,
  input  logic [ADDRESS_WIDTH-1:0]  bus_address,
  input  rggen_direction            bus_direction,
  input  logic [DATA_WIDTH-1:0]     bus_write_data,
  input  logic [DATA_WIDTH/8-1:0]   bus_write_strobe,
  output logic                      bus_ready,
  output logic [DATA_WIDTH-1:0]     bus_read_data,
  output rggen_status               bus_status,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDRESS_WIDTH-1:0]  paddr,
  output logic [2:0]                pprot,
  output logic [DATA_WIDTH-1:0]     pwdata,
  output logic [DATA_WIDTH/8-1:0]   pstrb,
  input  logic                      pready,
  input  logic                      pslverr,
  input  logic [DATA_WIDTH-1:0]     prdata,
  output logic                      timeout
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESPOND
  } state_e;

  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam int CW = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Counter holds completed ACCESS cycles, so the last permitted cycle sees LIMIT.
  localparam logic [CW-1:0] LIMIT = TIMEOUT_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;

  state_e          state;
  state_e          state_next;
  logic [CW-1:0]   count;
  logic            expired;

  assign pprot   = 3'b000;
  assign expired = TIMEOUT_EN && (count == LIMIT);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus_request) state_next = SETUP;
      SETUP:   state_next = ACCESS;
      ACCESS:  if (pready || expired) state_next = RESPOND;
      RESPOND: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psel          <= 1'b0;
      penable       <= 1'b0;
      pwrite        <= 1'b0;
      paddr         <= '0;
      pwdata        <= '0;
      pstrb         <= '0;
      bus_ready     <= 1'b0;
      bus_read_data <= '0;
      bus_status    <= RGGEN_OKAY;
      timeout       <= 1'b0;
      count         <= '0;
    end else begin
      psel      <= (state_next == SETUP) || (state_next == ACCESS);
      penable   <= (state_next == ACCESS);
      bus_ready <= (state_next == RESPOND);

      if (state == IDLE && bus_request) begin
        paddr  <= bus_address;
        pwrite <= (bus_direction == RGGEN_WRITE);
        pwdata <= bus_write_data;
        pstrb  <= (bus_direction == RGGEN_WRITE) ? bus_write_strobe : '0;
      end

      if (state_next == SETUP) begin
        count <= '0;
      end else if (TIMEOUT_EN && state == ACCESS && !pready && !expired) begin
        count <= count + 1'b1;
      end

      // pready takes priority over an expiring counter in the same cycle.
      if (state == ACCESS && state_next == RESPOND) begin
        timeout       <= !pready;
        bus_status    <= (pready && !pslverr) ? RGGEN_OKAY : RGGEN_SLAVE_ERROR;
        bus_read_data <= (pready && !pwrite) ? prdata : '0;
      end else begin
        timeout <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rggen_apb_bridge.sv
// Directed checks of the APB bridge built with a 4-cycle ACCESS timeout.
module tb_rggen_apb_bridge;
  import rggen_rtl_pkg::*;

  localparam int AW = 16;
  localparam int DW = 32;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 bus_request;
  logic [AW-1:0]        bus_address;
  rggen_direction       bus_direction;
  logic [DW-1:0]        bus_write_data;
  logic [DW/8-1:0]      bus_write_strobe;
  logic                 bus_ready;
  logic [DW-1:0]        bus_read_data;
  rggen_status          bus_status;
  logic                 psel, penable, pwrite;
  logic [AW-1:0]        paddr;
  logic [2:0]           pprot;
  logic [DW-1:0]        pwdata;
  logic [DW/8-1:0]      pstrb;
  logic                 pready, pslverr;
  logic [DW-1:0]        prdata;
  logic                 timeout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rggen_apb_bridge #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus_request     (bus_request),
    .bus_address     (bus_address),
    .bus_direction   (bus_direction),
    .bus_write_data  (bus_write_data),
    .bus_write_strobe(bus_write_strobe),
    .bus_ready       (bus_ready),
    .bus_read_data   (bus_read_data),
    .bus_status      (bus_status),
    .psel            (psel),
    .penable         (penable),
    .pwrite          (pwrite),
    .paddr           (paddr),
    .pprot           (pprot),
    .pwdata          (pwdata),
    .pstrb           (pstrb),
    .pready          (pready),
    .pslverr         (pslverr),
    .prdata          (prdata),
    .timeout         (timeout)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [AW-1:0] a, input rggen_direction d,
                         input logic [DW-1:0] wd, input logic [DW/8-1:0] st);
    bus_request      = 1'b1;
    bus_address      = a;
    bus_direction    = d;
    bus_write_data   = wd;
    bus_write_strobe = st;
  endtask

  initial begin : stim
    int setups;
    int readies;
    int ready_at;
    int setup2_at;
    logic [AW-1:0] addr2;

    rst_n = 1'b0; bus_request = 1'b0; bus_address = '0; bus_direction = RGGEN_READ;
    bus_write_data = '0; bus_write_strobe = '0; pready = 1'b0; pslverr = 1'b0; prdata = '0;
    #12;
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_bus_ready", bus_ready, 0);
    chk("rst_status", bus_status, RGGEN_OKAY);
    chk("rst_paddr", paddr, 0);
    chk("rst_timeout", timeout, 0);
    chk("pprot", pprot, 0);
    step();
    rst_n = 1'b1;
    step();

    // Zero-wait write
    request(16'h0010, RGGEN_WRITE, 32'hDEADBEEF, 4'hF);
    pready = 1'b1;
    step();
    chk("wr_setup_psel", psel, 1);
    chk("wr_setup_penable", penable, 0);
    chk("wr_pwrite", pwrite, 1);
    chk("wr_paddr", paddr, 16'h0010);
    chk("wr_pwdata", pwdata, 32'hDEADBEEF);
    chk("wr_pstrb", pstrb, 4'hF);
    chk("wr_setup_ready", bus_ready, 0);
    step();
    chk("wr_access_psel", psel, 1);
    chk("wr_access_penable", penable, 1);
    chk("wr_access_ready", bus_ready, 0);
    step();
    chk("wr_ready", bus_ready, 1);
    chk("wr_status", bus_status, RGGEN_OKAY);
    chk("wr_rdata", bus_read_data, 0);
    chk("wr_resp_psel", psel, 0);
    chk("wr_resp_timeout", timeout, 0);
    bus_request = 1'b0;
    pready = 1'b0;
    step();
    chk("wr_ready_pulse", bus_ready, 0);

    // Read stalled for 3 ACCESS cycles; ready on the 4th (also the timeout limit)
    request(16'h0004, RGGEN_READ, 32'h0, 4'hF);
    step();
    chk("rd_pstrb", pstrb, 0);
    chk("rd_pwrite", pwrite, 0);
    bus_request = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k == 4) begin
        pready = 1'b1;
        prdata = 32'h12345678;
      end
      chk("rd_stall_psel", psel, 1);
      chk("rd_stall_penable", penable, 1);
      chk("rd_stall_paddr", paddr, 16'h0004);
      chk("rd_stall_ready", bus_ready, 0);
    end
    step();
    chk("rd_ready", bus_ready, 1);
    chk("rd_data", bus_read_data, 32'h12345678);
    chk("rd_status", bus_status, RGGEN_OKAY);
    chk("rd_timeout", timeout, 0);
    pready = 1'b0;
    step();

    // Slave error
    request(16'h0008, RGGEN_READ, 32'h0, 4'h0);
    pready = 1'b1;
    pslverr = 1'b1;
    step();
    step();
    step();
    chk("err_ready", bus_ready, 1);
    chk("err_status", bus_status, RGGEN_SLAVE_ERROR);
    chk("err_timeout", timeout, 0);
    bus_request = 1'b0;
    pready = 1'b0;
    pslverr = 1'b0;
    step();

    // Timeout after 4 ACCESS cycles
    request(16'h0020, RGGEN_WRITE, 32'h11112222, 4'h3);
    step();
    bus_request = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("to_access_psel", psel, 1);
      chk("to_access_ready", bus_ready, 0);
    end
    step();
    chk("to_psel_drop", psel, 0);
    chk("to_ready", bus_ready, 1);
    chk("to_timeout", timeout, 1);
    chk("to_status", bus_status, RGGEN_SLAVE_ERROR);
    chk("to_rdata", bus_read_data, 0);
    step();
    chk("to_timeout_pulse", timeout, 0);
    chk("to_ready_pulse", bus_ready, 0);

    // pready on the final permitted cycle wins
    request(16'h0024, RGGEN_READ, 32'h0, 4'h0);
    step();
    bus_request = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k == 4) begin
        pready = 1'b1;
        prdata = 32'hCAFEF00D;
      end
    end
    step();
    chk("edge_ready", bus_ready, 1);
    chk("edge_status", bus_status, RGGEN_OKAY);
    chk("edge_timeout", timeout, 0);
    chk("edge_rdata", bus_read_data, 32'hCAFEF00D);
    pready = 1'b0;
    step();

    // Reset during ACCESS
    request(16'h0030, RGGEN_WRITE, 32'h55AA55AA, 4'hF);
    step();
    step();
    chk("mid_in_access", penable, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_psel", psel, 0);
    chk("mid_rst_penable", penable, 0);
    chk("mid_rst_paddr", paddr, 0);
    chk("mid_rst_pwdata", pwdata, 0);
    chk("mid_rst_pwrite", pwrite, 0);
    bus_request = 1'b0;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("mid_no_ready", bus_ready, 0);
    end
    request(16'h0040, RGGEN_READ, 32'h0, 4'h0);
    pready = 1'b1;
    prdata = 32'hA5A5A5A5;
    step();
    chk("fresh_paddr", paddr, 16'h0040);
    step();
    step();
    chk("fresh_ready", bus_ready, 1);
    chk("fresh_rdata", bus_read_data, 32'hA5A5A5A5);
    bus_request = 1'b0;
    step();

    // Back-to-back requests with request held high
    setups = 0; readies = 0; ready_at = 0; setup2_at = 0; addr2 = '0;
    request(16'h0050, RGGEN_WRITE, 32'h01020304, 4'hF);
    for (int i = 1; i <= 10; i++) begin
      step();
      if (psel && !penable) begin
        setups++;
        if (setups == 2) begin
          setup2_at = i;
          addr2 = paddr;
          bus_request = 1'b0;
        end
      end
      if (bus_ready) begin
        readies++;
        if (readies == 1) begin
          ready_at = i;
          bus_address = 16'h0054;
        end
      end
    end
    chk("b2b_setups", setups, 2);
    chk("b2b_readies", readies, 2);
    chk("b2b_gap", setup2_at - ready_at, 2);
    chk("b2b_addr2", addr2, 16'h0054);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rggen_apb_bridge.md
RGGEN_APB_BRIDGE -- requirements
Module: rggen_apb_bridge

Interface
REQ-001 Parameters SHALL be: ADDRESS_WIDTH, default 16, width of bus/APB address; DATA_WIDTH, default 32, data width (multiple of 8); TIMEOUT_CYCLES, default 0, ACCESS-phase cycle limit (0 disables timeout).
REQ-002 Port clk SHALL be an input, 1 bit, the clock.
REQ-003 Port rst_n SHALL be an input, 1 bit, the asynchronous active-low reset.
REQ-004 Port bus_request SHALL be an input, 1 bit, a request held high by upstream until it observes bus_ready.
REQ-005 Port bus_address SHALL be an input, ADDRESS_WIDTH bits, a region-relative address.
REQ-006 Port bus_direction SHALL be an input of type rggen_direction, RGGEN_READ/RGGEN_WRITE.
REQ-007 Ports bus_write_data (DATA_WIDTH) and bus_write_strobe (DATA_WIDTH/8) SHALL be inputs carrying write payload.
REQ-008 Port bus_ready SHALL be an output, 1 bit, a one-cycle completion pulse.
REQ-009 Ports bus_read_data (DATA_WIDTH) and bus_status (rggen_status) SHALL be outputs valid while bus_ready=1.
REQ-010 APB4 outputs SHALL be psel, penable, pwrite (1 bit each), paddr (ADDRESS_WIDTH), pprot (3), pwdata (DATA_WIDTH), pstrb (DATA_WIDTH/8); APB inputs SHALL be pready, pslverr (1 bit each), prdata (DATA_WIDTH).
REQ-011 Port timeout SHALL be an output, 1 bit, pulsed with bus_ready when a timeout ended the access.

Function
REQ-012 FSM states SHALL be IDLE, SETUP, ACCESS, RESPOND; all APB and bus_* outputs SHALL be registered.
REQ-013 In IDLE with bus_request=1, the next state SHALL be SETUP, capturing address, direction, write data and strobe into paddr/pwrite/pwdata/pstrb.
REQ-014 In SETUP, psel=1 and penable=0; the next state SHALL always be ACCESS.
REQ-015 In ACCESS, psel=1, penable=1, and APB payload SHALL remain stable until pready=1.
REQ-016 In ACCESS with pready=1, the next state SHALL be RESPOND; prdata SHALL be captured into bus_read_data for reads (writes return 0); bus_status SHALL be RGGEN_SLAVE_ERROR if pslverr=1, else RGGEN_OKAY.
REQ-017 In RESPOND, bus_ready=1 for exactly one cycle, psel=penable=0, and the next state SHALL be IDLE.
REQ-018 Minimum latency SHALL be: request seen at edge N, SETUP in cycle N+1, ACCESS in N+2, bus_ready in N+3 when pready=1 at N+2.
REQ-019 The RESPOND->IDLE cycle SHALL NOT sample bus_request; a new access SHALL start only from IDLE, so back-to-back accesses are spaced by at least one IDLE cycle.
REQ-020 pstrb SHALL be forced to all-zero for reads; pprot SHALL be fixed at 3'b000.
REQ-021 When TIMEOUT_CYCLES>0, a counter SHALL count ACCESS cycles; if pready is still 0 after TIMEOUT_CYCLES cycles, the FSM SHALL enter RESPOND with bus_status=RGGEN_SLAVE_ERROR, bus_read_data=0 and timeout=1, and psel SHALL drop.
REQ-022 pready=1 in the same cycle the counter reaches its limit SHALL count as a normal completion (pready wins).
REQ-023 The counter width SHALL be $clog2(TIMEOUT_CYCLES+1), and the counter SHALL clear on entry to SETUP.
REQ-024 bus_request deasserting outside IDLE SHALL be ignored; the APB transfer SHALL still complete.

Reset
REQ-025 Asynchronous reset SHALL force state IDLE; psel, penable, pwrite, paddr, pwdata, pstrb, bus_ready, bus_read_data and timeout to 0; bus_status to RGGEN_OKAY; and the counter to 0.
REQ-026 Reset asserted mid-transfer SHALL abort it immediately, with no bus_ready issued after release.

Structure
REQ-027 The FSM state enum SHALL be local to the module; rggen_direction and rggen_status SHALL come from rggen_rtl_pkg, and no new package types SHALL be added.
REQ-028 The block SHALL be a single module with no sub-modules.

Verification
REQ-029 Write 0x0000_0010, data 0xDEADBEEF, strobe 0xF, with pready tied 1 -> SETUP/ACCESS one cycle each, pwrite=1, pstrb=0xF, bus_ready at N+3, status OKAY.
REQ-030 Read 0x0004 with pready low for 3 ACCESS cycles, then prdata=0x12345678 -> payload stable throughout, bus_read_data=0x12345678, pstrb=0.
REQ-031 Read with pslverr=1 and pready=1 -> bus_status=RGGEN_SLAVE_ERROR, timeout=0.
REQ-032 TIMEOUT_CYCLES=4 with pready stuck 0 -> psel drops after 4 ACCESS cycles, bus_ready=1, timeout=1, SLAVE_ERROR; repeat with pready=1 on the 4th cycle -> OKAY.
REQ-033 rst_n pulsed low during ACCESS -> all outputs zero at once, no bus_ready; a fresh request afterward completes normally.
REQ-034 Two back-to-back requests from upstream -> exactly two APB transfers, with one IDLE cycle between RESPOND and the second SETUP.
